// File: rtl/bcd_serial_alu.sv
// bcd_serial_alu
// Bit-serial decimal/hex arithmetic unit with three working registers A, B, C
// of DIGITS 4-bit digits. One field-restricted operation runs per word time
// (W = 4*DIGITS cycles). Bits are processed LSB-first, one per cph2 cycle.
// Each digit is decimal-adjusted when its fourth bit has been summed.
//
// Optional feature macro: BCD_ALU_HEX_MODE_EN. When it is defined, op_hex
// selects radix 16 for the operation. When it is undefined, op_hex is
// ignored and all arithmetic is radix 10.
//
// Ports
//   cph2       system clock, rising edge
//   rst        synchronous active-high reset
//   op_valid   operation request
//   op_ready   operation can be accepted (idle)
//   op_code    operation select
//   op_hex     radix select, 1 = hex (only with BCD_ALU_HEX_MODE_EN)
//   fld_lo     lowest digit of the field, inclusive
//   fld_hi     highest digit of the field, inclusive (clamped to DIGITS-1)
//   ld_en      parallel load strobe, honoured only when idle
//   ld_sel     load target 0=A 1=B 2=C (3 ignored)
//   ld_data    parallel load value
//   a_q/b_q/c_q register contents, valid while busy=0
//   carry      result flag of the last completed operation
//   busy       operation in progress
//   start      first busy cycle (digit 0, bit 0)
//   done       one-cycle pulse in the completion cycle
//   state_dbg  FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: an operation is accepted on a rising edge where op_valid and
// op_ready are both high; op_code, op_hex and the field are captured on that
// edge. op_ready is low for the whole run and returns high together with
// done, so a new operation can be accepted in the completion cycle.
// An accepted operation wins over a parallel load in the same cycle.
//
// DIGITS must be at least 2.

module bcd_serial_alu #(
    parameter int DIGITS = 14,
    parameter int FW     = $clog2(DIGITS)
) (
    input  logic                cph2,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [3:0]          op_code,
    input  logic                op_hex,
    input  logic [FW-1:0]       fld_lo,
    input  logic [FW-1:0]       fld_hi,
    input  logic                ld_en,
    input  logic [1:0]          ld_sel,
    input  logic [4*DIGITS-1:0] ld_data,
    output logic [4*DIGITS-1:0] a_q,
    output logic [4*DIGITS-1:0] b_q,
    output logic [4*DIGITS-1:0] c_q,
    output logic                carry,
    output logic                busy,
    output logic                start,
    output logic                done,
    output logic                state_dbg
);

    localparam int            W        = 4 * DIGITS;
    localparam logic [FW-1:0] LAST_DIG = FW'(DIGITS - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_nxt;
    logic          accept, last_cycle;

    logic [3:0]    opc;
    logic [FW-1:0] lo_r, hi_r, hi_clamp;
    logic          empty_r;
    logic [1:0]    bit_cnt;
    logic [FW-1:0] dig_cnt;
    logic          cy;          // bit carry inside a digit, digit carry at digit end
    logic [2:0]    sbuf;        // raw sum bits 0..2 of the current digit
    logic [3:0]    hold;        // previous original A digit, source for SLA
    logic          flag;

    logic          hex;
    logic          is_sub, init_c, x_bit, y_bit;
    logic          arith, wr_a, wr_c, in_field, digit_end;
    logic          cin, s_bit, c_bit, dig_cy, flag_nxt;
    logic [3:0]    raw, dig_res, cur_a, cur_c, new_a, new_c;

`ifdef BCD_ALU_HEX_MODE_EN
    logic          hex_r;
`else
    logic          unused_hex;
    assign unused_hex = op_hex;
`endif

    assign hi_clamp = (fld_hi > LAST_DIG) ? LAST_DIG : fld_hi;

    // ---------------- FSM ----------------
    always_ff @(posedge cph2) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        last_cycle = (bit_cnt == 2'd3) && (dig_cnt == LAST_DIG);
        busy       = (state == RUN);
        op_ready   = (state == IDLE);
        start      = (state == RUN) && (bit_cnt == 2'd0) && (dig_cnt == '0);
        state_dbg  = state;
        case (state)
            IDLE: if (op_valid) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end
            RUN:  if (last_cycle) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- serial datapath ----------------
    always_comb begin
`ifdef BCD_ALU_HEX_MODE_EN
        hex = hex_r;
`else
        hex = 1'b0;
`endif
        is_sub = 1'b0;
        init_c = 1'b0;
        x_bit  = 1'b0;
        y_bit  = 1'b0;
        case (opc)
            4'd1:  begin x_bit = a_q[0]; y_bit = b_q[0]; end
            4'd2:  begin x_bit = a_q[0]; y_bit = b_q[0]; is_sub = 1'b1; end
            4'd3,
            4'd5:  begin x_bit = a_q[0]; y_bit = c_q[0]; end
            4'd4,
            4'd6,
            4'd11: begin x_bit = a_q[0]; y_bit = c_q[0]; is_sub = 1'b1; end
            4'd7:  begin x_bit = c_q[0]; init_c = 1'b1; end
            4'd8:  begin x_bit = c_q[0]; init_c = 1'b1; is_sub = 1'b1; end
            4'd9:  begin y_bit = c_q[0]; is_sub = 1'b1; end
            4'd10: begin y_bit = c_q[0]; init_c = 1'b1; is_sub = 1'b1; end
            default: ;
        endcase

        arith     = opc inside {[4'd1:4'd11]};
        wr_a      = opc inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd13, 4'd14, 4'd15};
        wr_c      = opc inside {[4'd5:4'd10], 4'd15};
        in_field  = !empty_r && (dig_cnt >= lo_r) && (dig_cnt <= hi_r);
        digit_end = (bit_cnt == 2'd3);

        // The chain restarts at the first field digit; whatever cy holds
        // from digits below the field is discarded there.
        cin   = (bit_cnt == 2'd0 && dig_cnt == lo_r) ? init_c : cy;
        s_bit = x_bit ^ y_bit ^ cin;
        c_bit = is_sub ? ((~x_bit & y_bit) | (~(x_bit ^ y_bit) & cin))
                       : ((x_bit & y_bit) | (cin & (x_bit ^ y_bit)));

        raw = {s_bit, sbuf};
        if (hex) begin
            dig_cy  = c_bit;
            dig_res = raw;
        end else if (is_sub) begin
            dig_cy  = c_bit;
            dig_res = c_bit ? raw - 4'd6 : raw;
        end else begin
            dig_cy  = c_bit || (raw > 4'd9);
            dig_res = dig_cy ? raw + 4'd6 : raw;
        end

        // At bit 3 the current digit's bits 0..2 have rotated to the top of
        // the register and bit 3 sits at position 0, all still original.
        cur_a = {a_q[0], a_q[W-1:W-3]};
        cur_c = {c_q[0], c_q[W-1:W-3]};

        case (opc)
            4'd13:   new_a = (dig_cnt == hi_r) ? 4'd0 : a_q[4:1];  // next digit, not yet rotated
            4'd14:   new_a = (dig_cnt == lo_r) ? 4'd0 : hold;
            4'd15:   new_a = cur_c;
            default: new_a = dig_res;
        endcase
        new_c = (opc == 4'd15) ? cur_a : dig_res;

        flag_nxt = flag;
        if (digit_end && in_field) begin
            if (arith && dig_cnt == hi_r) flag_nxt = dig_cy;
            if (opc == 4'd12)             flag_nxt = flag | (cur_c != 4'd0);
        end
    end

    always_ff @(posedge cph2) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            carry   <= 1'b0;
            done    <= 1'b0;
            opc     <= 4'd0;
            lo_r    <= '0;
            hi_r    <= '0;
            empty_r <= 1'b0;
            bit_cnt <= 2'd0;
            dig_cnt <= '0;
            cy      <= 1'b0;
            sbuf    <= 3'd0;
            hold    <= 4'd0;
            flag    <= 1'b0;
`ifdef BCD_ALU_HEX_MODE_EN
            hex_r   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                opc     <= op_code;
                lo_r    <= fld_lo;
                hi_r    <= hi_clamp;
                empty_r <= (fld_lo > hi_clamp);
                bit_cnt <= 2'd0;
                dig_cnt <= '0;
                flag    <= 1'b0;
`ifdef BCD_ALU_HEX_MODE_EN
                hex_r   <= op_hex;
`endif
            end else if (state == IDLE) begin
                if (ld_en) begin
                    case (ld_sel)
                        2'd0:    a_q <= ld_data;
                        2'd1:    b_q <= ld_data;
                        2'd2:    c_q <= ld_data;
                        default: ;
                    endcase
                end
            end else begin
                // Every register rotates right one bit per cycle and is back
                // in place after W cycles; a written digit replaces its raw
                // bits as it completes.
                bit_cnt <= bit_cnt + 2'd1;
                if (digit_end) dig_cnt <= dig_cnt + 1'b1;
                cy   <= digit_end ? dig_cy : c_bit;
                sbuf <= {s_bit, sbuf[2:1]};
                flag <= flag_nxt;
                b_q  <= {b_q[0], b_q[W-1:1]};
                a_q  <= (digit_end && in_field && wr_a) ? {new_a, a_q[W-4:1]}
                                                       : {a_q[0], a_q[W-1:1]};
                c_q  <= (digit_end && in_field && wr_c) ? {new_c, c_q[W-4:1]}
                                                       : {c_q[0], c_q[W-1:1]};
                if (digit_end) hold <= cur_a;
                if (last_cycle) begin
                    done  <= 1'b1;
                    carry <= flag_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Testbench for bcd_serial_alu: directed test-plan cases followed by random
// operations, each checked against a field-value arithmetic model.
module tb_bcd_serial_alu;

    localparam int DIGITS = 14;
    localparam int FW     = 4;
    localparam int W      = 4 * DIGITS;
`ifdef BCD_ALU_HEX_MODE_EN
    localparam bit HEX_EN = 1'b1;
`else
    localparam bit HEX_EN = 1'b0;
`endif

    logic          cph2, rst, op_valid, op_ready, op_hex, ld_en;
    logic [3:0]    op_code;
    logic [FW-1:0] fld_lo, fld_hi;
    logic [1:0]    ld_sel;
    logic [W-1:0]  ld_data, a_q, b_q, c_q;
    logic          carry, busy, start, done, state_dbg;

    bcd_serial_alu #(.DIGITS(DIGITS)) dut (
        .cph2(cph2), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_hex(op_hex), .fld_lo(fld_lo), .fld_hi(fld_hi),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
        .a_q(a_q), .b_q(b_q), .c_q(c_q), .carry(carry), .busy(busy),
        .start(start), .done(done), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        cph2 = 1'b0;
        forever #5 cph2 = ~cph2;
    end

    // ---------------- scoreboard ----------------
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_a, m_b, m_c;
    bit           m_cy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge cph2);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic longint unsigned fval(input logic [W-1:0] r, input int lo, input int n,
                                             input longint unsigned rad);
        longint unsigned v = 0;
        for (int i = n - 1; i >= 0; i--) v = v * rad + 64'(r[4*(lo+i) +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] fput(input logic [W-1:0] r, input int lo, input int n,
                                          input longint unsigned rad, input longint unsigned v);
        logic [W-1:0] t = r;
        for (int i = 0; i < n; i++) begin
            t[4*(lo+i) +: 4] = 4'(v % rad);
            v = v / rad;
        end
        return t;
    endfunction

    task automatic msub(input longint unsigned x, input longint unsigned y, input longint unsigned ci,
                        input longint unsigned m, output longint unsigned r, output bit bo);
        if (x >= y + ci) begin r = x - y - ci;     bo = 1'b0; end
        else             begin r = x + m - y - ci; bo = 1'b1; end
    endtask

    task automatic model_op(input logic [3:0] code, input bit hx, input int lo, input int hi);
        int hc, n;
        longint unsigned rad, m, a, b, c, r;
        bit bo;
        hc   = (hi > DIGITS - 1) ? DIGITS - 1 : hi;
        m_cy = 1'b0;
        if (code == 4'd0 || lo > hc) return;
        rad = (hx && HEX_EN) ? 16 : 10;
        n   = hc - lo + 1;
        m   = 1;
        for (int i = 0; i < n; i++) m = m * rad;
        a = fval(m_a, lo, n, rad);
        b = fval(m_b, lo, n, rad);
        c = fval(m_c, lo, n, rad);
        case (code)
            4'd1:  begin r = a + b; m_cy = (r >= m); m_a = fput(m_a, lo, n, rad, r % m); end
            4'd2:  begin msub(a, b, 0, m, r, bo); m_cy = bo; m_a = fput(m_a, lo, n, rad, r); end
            4'd3:  begin r = a + c; m_cy = (r >= m); m_a = fput(m_a, lo, n, rad, r % m); end
            4'd4:  begin msub(a, c, 0, m, r, bo); m_cy = bo; m_a = fput(m_a, lo, n, rad, r); end
            4'd5:  begin r = a + c; m_cy = (r >= m); m_c = fput(m_c, lo, n, rad, r % m); end
            4'd6:  begin msub(a, c, 0, m, r, bo); m_cy = bo; m_c = fput(m_c, lo, n, rad, r); end
            4'd7:  begin r = c + 1; m_cy = (r >= m); m_c = fput(m_c, lo, n, rad, r % m); end
            4'd8:  begin msub(c, 0, 1, m, r, bo); m_cy = bo; m_c = fput(m_c, lo, n, rad, r); end
            4'd9:  begin msub(0, c, 0, m, r, bo); m_cy = bo; m_c = fput(m_c, lo, n, rad, r); end
            4'd10: begin msub(0, c, 1, m, r, bo); m_cy = bo; m_c = fput(m_c, lo, n, rad, r); end
            4'd11: m_cy = (a < c);
            4'd12: m_cy = (c != 0);
            4'd13: m_a = fput(m_a, lo, n, rad, a / rad);
            4'd14: m_a = fput(m_a, lo, n, rad, (a * rad) % m);
            4'd15: begin m_a = fput(m_a, lo, n, rad, c); m_c = fput(m_c, lo, n, rad, a); end
            default: ;
        endcase
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic do_load(input logic [1:0] sel, input logic [W-1:0] data);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_data = data;
        tick();
        ld_en   = 1'b0;
        case (sel)
            2'd0: m_a = data;
            2'd1: m_b = data;
            2'd2: m_c = data;
            default: ;
        endcase
    endtask

    // noise=1 also drives a load at the accept edge and keeps op_valid,
    // op inputs and ld_en busy during the run; all of it must be ignored.
    task automatic run_op(input logic [3:0] code, input bit hx, input int lo, input int hi, input bit noise);
        int cycles;
        model_op(code, hx, lo, hi);
        exp_q.push_back(m_a);
        exp_q.push_back(m_b);
        exp_q.push_back(m_c);
        exp_q.push_back(W'(m_cy));
        op_valid = 1'b1;
        op_code  = code;
        op_hex   = hx;
        fld_lo   = FW'(lo);
        fld_hi   = FW'(hi);
        if (noise) begin
            ld_en   = 1'b1;
            ld_sel  = 2'($urandom_range(0, 2));
            ld_data = rand_bcd();
        end
        check("ready_before", 64'(op_ready), 64'd1);
        tick();
        check("start", 64'(start), 64'd1);
        if (noise) begin
            op_code = 4'($urandom_range(1, 15));
            fld_lo  = 4'd0;
            fld_hi  = 4'd13;
            ld_data = rand_bcd();
        end else begin
            op_valid = 1'b0;
            ld_en    = 1'b0;
        end
        cycles = 0;
        while (done !== 1'b1 && cycles < W + 20) begin
            tick();
            cycles++;
        end
        op_valid = 1'b0;
        ld_en    = 1'b0;
        check("latency", 64'(cycles), 64'(W));
        check("busy_at_done", 64'(busy), 64'd0);
        check("ready_at_done", 64'(op_ready), 64'd1);
        check("reg_a", 64'(a_q), 64'(exp_q.pop_front()));
        check("reg_b", 64'(b_q), 64'(exp_q.pop_front()));
        check("reg_c", 64'(c_q), 64'(exp_q.pop_front()));
        check("carry", 64'(carry), 64'(exp_q.pop_front()));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit saw_done;
        int lo, hi;
        rst = 1'b1; op_valid = 1'b0; op_code = 4'd0; op_hex = 1'b0;
        fld_lo = '0; fld_hi = '0; ld_en = 1'b0; ld_sel = 2'd0; ld_data = '0;
        m_a = '0; m_b = '0; m_c = '0; m_cy = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_a", 64'(a_q), 64'd0);
        check("rst_b", 64'(b_q), 64'd0);
        check("rst_c", 64'(c_q), 64'd0);
        check("rst_carry", 64'(carry), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_start", 64'(start), 64'd0);
        check("rst_ready", 64'(op_ready), 64'd1);

        // Case 1
        do_load(2'd0, W'(56'h0999));
        do_load(2'd1, W'(56'h0001));
        run_op(4'd1, 1'b0, 0, 3, 1'b0);
        check("c1_a", 64'(a_q), 64'h1000);
        check("c1_b", 64'(b_q), 64'h0001);
        check("c1_carry", 64'(carry), 64'd0);

        // Case 2
        do_load(2'd0, W'(56'h77099));
        do_load(2'd1, W'(56'h01));
        run_op(4'd1, 1'b0, 0, 1, 1'b0);
        check("c2_a", 64'(a_q), 64'h77000);
        check("c2_carry", 64'(carry), 64'd1);

        // Case 3
        do_load(2'd2, W'(56'h1));
        run_op(4'd9, 1'b0, 0, 13, 1'b0);
        check("c3_c", 64'(c_q), 64'h99999999999999);
        check("c3_carry", 64'(carry), 64'd1);
        do_load(2'd2, '0);
        run_op(4'd9, 1'b0, 0, 13, 1'b0);
        check("c3_c_zero", 64'(c_q), 64'd0);
        check("c3_carry_zero", 64'(carry), 64'd0);

        // Case 4
        do_load(2'd0, W'(56'h9));
        do_load(2'd2, W'(56'h1));
        run_op(4'd3, 1'b1, 0, 3, 1'b0);
        check("c4_a", 64'(a_q), HEX_EN ? 64'hA : 64'h10);

        // Case 5
        do_load(2'd0, W'(56'h5));
        do_load(2'd2, W'(56'h7));
        run_op(4'd11, 1'b0, 0, 0, 1'b0);
        check("c5_carry", 64'(carry), 64'd1);
        check("c5_a", 64'(a_q), 64'h5);
        check("c5_c", 64'(c_q), 64'h7);
        do_load(2'd0, W'(56'h123));
        run_op(4'd14, 1'b0, 0, 2, 1'b0);
        check("c5_sla", 64'(a_q), 64'h230);

        // Back-to-back: second op is issued in the done cycle of the first
        do_load(2'd2, rand_bcd());
        run_op(4'd7, 1'b0, 2, 9, 1'b0);
        run_op(4'd8, 1'b0, 0, 13, 1'b0);

        // Empty field and clamped fld_hi
        do_load(2'd0, rand_bcd());
        do_load(2'd1, rand_bcd());
        run_op(4'd1, 1'b0, 5, 3, 1'b0);
        run_op(4'd2, 1'b0, 10, 15, 1'b0);
        run_op(4'd13, 1'b0, 3, 15, 1'b0);

        // Loads and op changes during RUN are ignored; load at accept dropped
        do_load(2'd2, rand_bcd());
        run_op(4'd12, 1'b0, 0, 13, 1'b1);
        run_op(4'd15, 1'b0, 1, 12, 1'b1);

        // Case 6: reset in cycle 10 of RUN
        do_load(2'd0, rand_bcd());
        do_load(2'd1, rand_bcd());
        op_valid = 1'b1; op_code = 4'd1; op_hex = 1'b0; fld_lo = 4'd0; fld_hi = 4'd13;
        tick();
        op_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_a = '0; m_b = '0; m_c = '0;
        check("c6_busy", 64'(busy), 64'd0);
        check("c6_done", 64'(done), 64'd0);
        check("c6_a", 64'(a_q), 64'd0);
        check("c6_b", 64'(b_q), 64'd0);
        check("c6_c", 64'(c_q), 64'd0);
        check("c6_carry", 64'(carry), 64'd0);
        saw_done = 1'b0;
        repeat (W + 5) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("c6_no_done", 64'(saw_done), 64'd0);
        do_load(2'd0, W'(56'h2));
        do_load(2'd1, W'(56'h3));
        run_op(4'd1, 1'b0, 0, 13, 1'b0);
        check("c6_a5", 64'(a_q), 64'h5);

        // Random operations
        for (int k = 0; k < 40; k++) begin
            do_load(2'd0, rand_bcd());
            do_load(2'd1, rand_bcd());
            do_load(2'd2, rand_bcd());
            lo = $urandom_range(0, 13);
            hi = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(lo, 15);
            run_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), lo, hi,
                   1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
